asinghani_xwalk_sched: RTL and testbench
========================================

ASINGHANI_XWALK_SCHED -- requirements
Module: asinghani_xwalk_sched

Interface
REQ-001 The block SHALL have parameter YELLOW_T, default 200, meaning ticks of vehicle yellow.
REQ-002 The block SHALL have parameter CLEAR_T, default 100, meaning ticks of all-red before walk.
REQ-003 The block SHALL have parameter WALK_T, default 1200, meaning ticks of solid walk.
REQ-004 The block SHALL have parameter FLASH_T, default 600, meaning ticks of flashing no_walk.
REQ-005 The block SHALL have parameter BLINK_T, default 100, meaning ticks per flash half-period.
REQ-006 The block SHALL have parameter GUARD_T, default 100, meaning ticks of solid no_walk plus red after flash.
REQ-007 The block SHALL have parameter HOLD_T, default 500, meaning minimum vehicle-green ticks between services.
REQ-008 The block SHALL have port clock, input, 1, the single clock.
REQ-009 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-010 The block SHALL have port tick, input, 1, timebase enable (one cycle per 10 ms).
REQ-011 The block SHALL have port btn, input, 2, walk request level per crossing (bit 0 = A, bit 1 = B).
REQ-012 The block SHALL have ports red, yellow, green, output, 2 each, vehicle head per crossing.
REQ-013 The block SHALL have ports walk, no_walk, output, 2 each, pedestrian head per crossing.
REQ-014 The block SHALL have port beeper, output, 1, the shared audible signal.
REQ-015 The block SHALL have port grant, output, 2, one-hot crossing being served, 0 when none.
REQ-016 The block SHALL have port pending, output, 2, latched unserved requests.

Function
REQ-017 States SHALL be IDLE, YELLOW, CLEAR, WALK, FLASH, GUARD, HOLD; one crossing served at a time.
REQ-018 Phase counter SHALL increment only on cycles with tick=1; it SHALL clear on every state change; a timed state SHALL exit on the tick where counter == T-1.
REQ-019 pending[i] SHALL set on any cycle btn[i]=1, except while grant[i]=1 in YELLOW, CLEAR or WALK, where btn[i] SHALL be ignored.
REQ-020 In IDLE with pending != 0, the next state SHALL be YELLOW; grant SHALL be registered on the same edge and the granted pending bit cleared, regardless of tick.
REQ-021 Arbitration SHALL be round-robin: a single pending crossing wins; if both are pending, the crossing not in last_served wins; last_served SHALL update at grant.
REQ-022 Transitions SHALL be YELLOW->CLEAR->WALK->FLASH->GUARD->HOLD->IDLE; on entry to HOLD, grant SHALL clear to 0.
REQ-023 Non-granted crossing: green=1, no_walk=1, all others 0.
REQ-024 Granted crossing: yellow in YELLOW; red in CLEAR, WALK, FLASH and GUARD; walk=1 only in WALK.
REQ-025 Granted crossing no_walk SHALL be 1 in YELLOW, CLEAR and GUARD, 0 in WALK, and in FLASH 1 when floor(counter/BLINK_T) is odd.
REQ-026 In HOLD and IDLE, both crossings SHALL show green=1 and no_walk=1.
REQ-027 beeper SHALL equal OR of walk.
REQ-028 Exactly one of red, yellow and green per crossing SHALL be 1 on every cycle, and walk & no_walk SHALL never both be 1.
REQ-029 Counter width SHALL be sized by $clog2 of the largest T parameter; all T parameters SHALL be >= 1.
REQ-030 Requests arriving in HOLD SHALL be latched and served only after HOLD expires.
REQ-031 tick=0 SHALL freeze all timing, so that outputs hold their values.

Reset
REQ-032 While reset_n=0 at a clock edge, the block SHALL set state=IDLE, counter=0, pending=0, grant=0 and last_served=B.
REQ-033 The reset outputs SHALL be green=2'b11, no_walk=2'b11, with red, yellow, walk and beeper all 0.
REQ-034 Reset asserted mid-service SHALL abort the service on that edge with no partial sequence.
REQ-035 Requests present during reset SHALL be discarded.

Structure
REQ-036 Package asinghani_xwalk_pkg SHALL hold the state enum, the default timing constants and crossing index constants (XA=0, XB=1).
REQ-037 Sub-module asinghani_xwalk_timer SHALL implement the tick-gated phase counter with clear and done outputs; arbitration and output decode SHALL stay in the top.

Verification (tick=1 every cycle, defaults)
REQ-038 Single request: btn=01 for 1 cycle at edge k -> grant=01 and yellow[0] during k+1..k+200; walk[0]=beeper=1 during k+301..k+1500; grant=0 from k+2201; green[0] throughout HOLD.
REQ-039 Simultaneous request after reset: btn=11 -> A is served first, then B is granted on the cycle after HOLD ends (k+2702); pending=10 during A's service.
REQ-040 Flash pattern: no_walk[0] is 0 for FLASH counter 0-99, 1 for 100-199, and so on, giving 3 pulses before GUARD.
REQ-041 Ignored press: btn[0] held during A's WALK -> pending[0] stays 0; press during A's FLASH -> pending[0]=1 and A is re-served after HOLD.
REQ-042 Reset mid-WALK: reset_n=0 for 1 cycle -> next cycle green=11, no_walk=11, beeper=0, pending=00, grant=00.
REQ-043 Tick gating: tick=0 for 50 cycles mid-YELLOW -> yellow phase is extended by exactly 50 cycles, and the invariants of REQ-028 hold on every cycle.

Source files
------------

// File: rtl/asinghani_xwalk_pkg.sv
// asinghani_xwalk_pkg: shared states, default timings and crossing indices
package asinghani_xwalk_pkg;
  typedef enum logic [2:0] {S_IDLE, S_YELLOW, S_CLEAR, S_WALK, S_FLASH, S_GUARD, S_HOLD} state_t;
  localparam int YELLOW_T_D = 200;
  localparam int CLEAR_T_D = 100;
  localparam int WALK_T_D = 1200;
  localparam int FLASH_T_D = 600;
  localparam int BLINK_T_D = 100;
  localparam int GUARD_T_D = 100;
  localparam int HOLD_T_D = 500;
  localparam int XA = 0;
  localparam int XB = 1;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/asinghani_xwalk_timer.sv
// asinghani_xwalk_timer: tick-gated phase counter with clear and terminal-count flag
module asinghani_xwalk_timer #(
  parameter int W = 11
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_tick,
  input  logic         i_clr,
  input  logic [W-1:0] i_lim,
  output logic [W-1:0] o_cnt,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  // count ticks within the current phase; restart on reset or phase change
  always_ff @(posedge i_clock)
    if (!i_reset_n || i_clr) r_cnt <= '0;
    else if (i_tick) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
  assign o_done = i_tick && r_cnt == i_lim;
endmodule

// File: rtl/asinghani_xwalk_sched.sv
// asinghani_xwalk_sched: two-crossing pedestrian walk scheduler with round-robin service
module asinghani_xwalk_sched
  import asinghani_xwalk_pkg::*;
#(
  parameter int YELLOW_T = YELLOW_T_D,
  parameter int CLEAR_T = CLEAR_T_D,
  parameter int WALK_T = WALK_T_D,
  parameter int FLASH_T = FLASH_T_D,
  parameter int BLINK_T = BLINK_T_D,
  parameter int GUARD_T = GUARD_T_D,
  parameter int HOLD_T = HOLD_T_D
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [1:0] btn,
  output logic [1:0] red,
  output logic [1:0] yellow,
  output logic [1:0] green,
  output logic [1:0] walk,
  output logic [1:0] no_walk,
  output logic       beeper,
  output logic [1:0] grant,
  output logic [1:0] pending
);
  localparam int MAX_T = imax(imax(imax(YELLOW_T, CLEAR_T), imax(WALK_T, FLASH_T)),
                              imax(imax(BLINK_T, GUARD_T), HOLD_T));
  localparam int CW = MAX_T > 1 ? $clog2(MAX_T) : 1;
  state_t r_state, w_nxt;
  logic [1:0] r_grant, r_pend, w_grant, w_pend;
  logic r_last, w_last, w_win, w_clr, w_done, w_blink;
  logic [CW-1:0] w_cnt, w_lim;

  assign w_clr = w_nxt != r_state;

  asinghani_xwalk_timer #(.W(CW)) u_timer (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .i_tick   (tick),
    .i_clr    (w_clr),
    .i_lim    (w_lim),
    .o_cnt    (w_cnt),
    .o_done   (w_done)
  );

  // terminal count of the current timed phase
  always_comb
    w_lim = r_state == S_YELLOW ? CW'(YELLOW_T - 1) :
            r_state == S_CLEAR  ? CW'(CLEAR_T - 1)  :
            r_state == S_WALK   ? CW'(WALK_T - 1)   :
            r_state == S_FLASH  ? CW'(FLASH_T - 1)  :
            r_state == S_GUARD  ? CW'(GUARD_T - 1)  :
            r_state == S_HOLD   ? CW'(HOLD_T - 1)   : '0;

  // next state, request latching and round-robin grant
  always_comb begin
    w_nxt = r_state;
    w_grant = r_grant;
    w_last = r_last;
    w_win = &r_pend ? ~r_last : r_pend[1];
    w_pend = r_pend | (btn & ~(r_grant & {2{r_state inside {S_YELLOW, S_CLEAR, S_WALK}}}));
    case (r_state)
      S_IDLE:
        if (|r_pend) begin
          w_nxt = S_YELLOW;
          w_grant = '0;
          w_grant[w_win] = 1'b1;
          w_last = w_win;
          w_pend[w_win] = 1'b0;
        end
      S_YELLOW: if (w_done) w_nxt = S_CLEAR;
      S_CLEAR:  if (w_done) w_nxt = S_WALK;
      S_WALK:   if (w_done) w_nxt = S_FLASH;
      S_FLASH:  if (w_done) w_nxt = S_GUARD;
      S_GUARD:
        if (w_done) begin
          w_nxt = S_HOLD;
          w_grant = '0;
        end
      S_HOLD:   if (w_done) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  // state, grant, pending and last-served registers; reset drops any request in flight
  always_ff @(posedge clock)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_pend <= '0;
      r_last <= 1'(XB);
    end else begin
      r_state <= w_nxt;
      r_grant <= w_grant;
      r_pend <= w_pend;
      r_last <= w_last;
    end

  assign w_blink = ((32'(w_cnt) / 32'(BLINK_T)) % 32'd2) != 32'd0;

  // lamp decode: unserved crossings stay green with solid no_walk
  always_comb begin
    red = '0;
    yellow = '0;
    green = '0;
    walk = '0;
    no_walk = '0;
    for (int i = 0; i < 2; i++)
      if (!r_grant[i]) begin
        green[i] = 1'b1;
        no_walk[i] = 1'b1;
      end else begin
        yellow[i] = r_state == S_YELLOW;
        red[i] = r_state != S_YELLOW;
        walk[i] = r_state == S_WALK;
        no_walk[i] = r_state == S_FLASH ? w_blink : r_state != S_WALK;
      end
  end

  assign beeper = |walk;
  assign grant = r_grant;
  assign pending = r_pend;
endmodule

// File: tb/tb_asinghani_xwalk_sched.sv
// tb_asinghani_xwalk_sched: directed and random checks against a service-timeline model
module tb_asinghani_xwalk_sched;
  localparam int Y = 200, C = 100, W = 1200, F = 600, B = 100, G = 100, H = 500;
  localparam int TOT = Y + C + W + F + G + H;
  logic clock = 1'b0, reset_n = 1'b0, tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] red, yellow, green, walk, no_walk, grant, pending;
  logic beeper;
  int checks = 0, errors = 0;
  bit m_busy = 0;
  int m_x = 0, m_e = 0, m_last = 1;
  logic [1:0] m_pend = 2'b00;

  asinghani_xwalk_sched dut (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick),
    .btn    (btn),
    .red    (red),
    .yellow (yellow),
    .green  (green),
    .walk   (walk),
    .no_walk(no_walk),
    .beeper (beeper),
    .grant  (grant),
    .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic [1:0] er, ey, eg, ew, en, egr;
    er = 0; ey = 0; eg = 0; ew = 0; en = 0; egr = 0;
    for (int i = 0; i < 2; i++)
      if (m_busy && m_x == i && m_e < TOT - H) begin
        egr[i] = 1'b1;
        if (m_e < Y) begin
          ey[i] = 1'b1;
          en[i] = 1'b1;
        end else begin
          er[i] = 1'b1;
          if (m_e < Y + C) en[i] = 1'b1;
          else if (m_e < Y + C + W) ew[i] = 1'b1;
          else if (m_e < Y + C + W + F) en[i] = ((m_e - Y - C - W) / B) % 2 == 1;
          else en[i] = 1'b1;
        end
      end else begin
        eg[i] = 1'b1;
        en[i] = 1'b1;
      end
    chk("red", red, er);
    chk("yellow", yellow, ey);
    chk("green", green, eg);
    chk("walk", walk, ew);
    chk("no_walk", no_walk, en);
    chk("beeper", beeper, |ew);
    chk("grant", grant, egr);
    chk("pending", pending, m_pend);
    for (int i = 0; i < 2; i++) begin
      chk("one_lamp", $countones({red[i], yellow[i], green[i]}), 1);
      chk("walk_and_no_walk", walk[i] & no_walk[i], 0);
    end
  endtask

  task automatic step(input logic rn, input logic tk, input logic [1:0] b);
    logic [1:0] old;
    int w;
    reset_n = rn;
    tick = tk;
    btn = b;
    @(posedge clock);
    if (!rn) begin
      m_busy = 0; m_e = 0; m_pend = 0; m_last = 1;
    end else begin
      old = m_pend;
      for (int i = 0; i < 2; i++)
        if (b[i] && !(m_busy && m_x == i && m_e < Y + C + W)) m_pend[i] = 1'b1;
      if (!m_busy) begin
        if (old != 0) begin
          w = (old == 2'b11) ? 1 - m_last : (old[1] ? 1 : 0);
          m_busy = 1; m_x = w; m_e = 0; m_last = w; m_pend[w] = 1'b0;
        end
      end else if (tk) begin
        m_e++;
        if (m_e == TOT) m_busy = 0;
      end
    end
    @(negedge clock);
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1, 1'b1, 2'b00);
  endtask

  initial begin
    logic [1:0] b;
    logic tk, rn;
    repeat (3) step(1'b0, 1'b1, 2'b11);
    chk("rst_green", green, 2'b11);
    chk("rst_no_walk", no_walk, 2'b11);
    chk("rst_pending", pending, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    chk("rst_discard", pending, 2'b00);
    step(1'b1, 1'b1, 2'b01);
    run(1);
    chk("single_grant", grant, 2'b01);
    chk("single_yellow_first", yellow, 2'b01);
    run(199);
    chk("single_yellow_last", yellow, 2'b01);
    run(1);
    chk("single_red_clear", red, 2'b01);
    run(100);
    chk("single_walk_first", walk, 2'b01);
    chk("single_beeper", beeper, 1'b1);
    run(1199);
    chk("single_walk_last", walk, 2'b01);
    run(1);
    chk("flash_low", no_walk, 2'b10);
    run(100);
    chk("flash_high", no_walk, 2'b11);
    run(599);
    chk("guard_grant", grant, 2'b01);
    run(1);
    chk("hold_grant", grant, 2'b00);
    chk("hold_green", green, 2'b11);
    run(500);
    step(1'b0, 1'b1, 2'b00);
    step(1'b1, 1'b1, 2'b11);
    run(1);
    chk("both_grant_a", grant, 2'b01);
    chk("both_pending_b", pending, 2'b10);
    run(2700);
    chk("both_idle", grant, 2'b00);
    run(1);
    chk("both_grant_b", grant, 2'b10);
    run(2700);
    step(1'b1, 1'b1, 2'b01);
    run(301);
    repeat (10) step(1'b1, 1'b1, 2'b01);
    chk("walk_press_ignored", pending, 2'b00);
    run(1190);
    step(1'b1, 1'b1, 2'b01);
    chk("flash_press_latched", pending, 2'b01);
    run(1199);
    chk("reserve_idle", grant, 2'b00);
    run(1);
    chk("reserve_grant", grant, 2'b01);
    step(1'b1, 1'b1, 2'b10);
    run(399);
    chk("mid_walk", walk, 2'b01);
    step(1'b0, 1'b1, 2'b00);
    chk("abort_green", green, 2'b11);
    chk("abort_beeper", beeper, 1'b0);
    chk("abort_pending", pending, 2'b00);
    chk("abort_grant", grant, 2'b00);
    step(1'b1, 1'b1, 2'b01);
    run(50);
    repeat (50) step(1'b1, 1'b0, 2'b00);
    run(150);
    chk("gated_yellow_last", yellow, 2'b01);
    run(1);
    chk("gated_yellow_end", yellow, 2'b00);
    run(2500);
    repeat (20000) begin
      b[0] = ($urandom % 400) == 0;
      b[1] = ($urandom % 400) == 0;
      tk = ($urandom % 20) != 0;
      rn = ($urandom % 5000) != 0;
      step(rn, tk, b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
